// File: rtl/tohost_pkg.sv
// Shared types and constants for the tohost result monitor.
package tohost_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        PASS    = 2'd1,
        FAIL    = 2'd2,
        TIMEOUT = 2'd3
    } tohost_state_e;

    localparam logic [31:0] PASS_CODE           = 32'h0000_0001;
    localparam logic [31:0] TOHOST_ADDR_DEFAULT = 32'h0000_1000;

    // Only full-word stores to the exact tohost word count as a result write.
    function automatic logic is_tohost_write(
        input logic        valid,
        input logic [31:0] addr,
        input logic [3:0]  strb,
        input logic [31:0] tohost_addr
    );
        return valid && (addr == tohost_addr) && (strb == 4'hF);
    endfunction

endpackage

// File: rtl/tohost_decode.sv
// Combinational qualification and decode of a store to the tohost word.
module tohost_decode
    import tohost_pkg::*;
#(
    parameter logic [31:0] TOHOST_ADDR = TOHOST_ADDR_DEFAULT
) (
    input  logic        st_valid,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_wdata,
    input  logic [3:0]  st_wstrb,
    output logic        is_pass,
    output logic        is_fail,
    output logic [30:0] fail_num
);

    logic qual;

    always_comb begin
        qual    = is_tohost_write(st_valid, st_addr, st_wstrb, TOHOST_ADDR);
        is_pass = qual && (st_wdata == PASS_CODE);
        // Odd data other than the pass code encodes a failing test number.
        is_fail = qual && st_wdata[0] && (st_wdata != PASS_CODE);
        fail_num = is_fail ? st_wdata[31:1] : 31'd0;
    end

endmodule

// File: rtl/tohost_monitor.sv
// Watches core stores for a tohost result write and reports a sticky verdict.
// Timeout verdict is only built when TOHOST_MONITOR_TIMEOUT_EN is defined.
module tohost_monitor
    import tohost_pkg::*;
#(
    parameter logic [31:0] TOHOST_ADDR    = TOHOST_ADDR_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 5000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        st_valid,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_wdata,
    input  logic [3:0]  st_wstrb,
    input  logic        retire,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [30:0] fail_num,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
);

    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

`ifdef TOHOST_MONITOR_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    tohost_state_e state_q;
    logic [30:0]   fail_num_q;
    logic [31:0]   cycle_cnt_q;
    logic [31:0]   instret_cnt_q;

    logic        dec_pass;
    logic        dec_fail;
    logic [30:0] dec_fail_num;
    logic        timeout_hit;

    tohost_decode #(
        .TOHOST_ADDR (TOHOST_ADDR)
    ) u_decode (
        .st_valid (st_valid),
        .st_addr  (st_addr),
        .st_wdata (st_wdata),
        .st_wstrb (st_wstrb),
        .is_pass  (dec_pass),
        .is_fail  (dec_fail),
        .fail_num (dec_fail_num)
    );

    assign timeout_hit = TIMEOUT_EN && (cycle_cnt_q == TIMEOUT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            fail_num_q    <= '0;
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            unique case (state_q)
                RUN: begin
                    // Counters include the cycle of the terminating event.
                    cycle_cnt_q   <= cycle_cnt_q + 32'd1;
                    instret_cnt_q <= instret_cnt_q + {31'd0, retire};
                    if (dec_pass) begin
                        state_q <= PASS;
                    end else if (dec_fail) begin
                        state_q    <= FAIL;
                        fail_num_q <= dec_fail_num;
                    end else if (timeout_hit) begin
`ifdef TOHOST_MONITOR_TIMEOUT_EN
                        state_q <= TIMEOUT;
`else
                        state_q <= RUN;
`endif
                    end
                end
                PASS, FAIL, TIMEOUT: state_q <= state_q;
                default:             state_q <= RUN;
            endcase
        end
    end

    assign done        = (state_q != RUN);
    assign pass        = (state_q == PASS);
`ifdef TOHOST_MONITOR_TIMEOUT_EN
    assign timeout     = (state_q == TIMEOUT);
`else
    assign timeout     = 1'b0;
`endif
    assign fail_num    = fail_num_q;
    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;

endmodule
